exp_decay_lut_arbiter: RTL and testbench

Time-shares one 8-bit exponential-decay lookup table (8-bit index in, 8-bit value out, combinational read) between NUM_VOICES envelope generators. Each voice raises a request with an 8-bit index. A round-robin arbiter grants one request per clock and pipelines the index into the table. The looked-up value returns to the owning voice with a one-hot valid tag. It sits between the per-voice envelope generators and the single decay-table instance, so the table is not replicated per voice.

---
 rtl/exp_decay_lut_arbiter_pkg.sv | 8 +
 rtl/exp_decay_lut_arbiter_rr_priority_pick.sv | 36 +++
 rtl/exp_decay_lut_arbiter.sv | 98 +++++++++
 tb/tb_exp_decay_lut_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_decay_lut_arbiter_pkg.sv
// Shared constants for the decay-table arbiter and its helpers.
package exp_decay_lut_arbiter_pkg;

    // Decay table geometry: 8-bit index in, 8-bit value out.
    localparam int unsigned LUT_IDX_W  = 8;
    localparam int unsigned LUT_DATA_W = 8;

endpackage

// File: rtl/exp_decay_lut_arbiter_rr_priority_pick.sv
// Round-robin priority picker: grants the first requester at or after ptr_i,
// wrapping modulo N. Purely combinational so it can front any shared table.
module rr_priority_pick
    import exp_decay_lut_arbiter_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [ID_W-1:0] id_o
);

    // Scan ptr_i, ptr_i+1, ... and keep the first active request.
    always_comb begin
        int unsigned pos;
        logic        found;
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        pos     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && req_i[pos[ID_W-1:0]]) begin
                grant_o[pos[ID_W-1:0]] = 1'b1;
                id_o                   = pos[ID_W-1:0];
                found                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exp_decay_lut_arbiter.sv
// Time-shares one exponential-decay lookup table between NUM_VOICES envelope
// generators: round-robin grant, registered index to the table, registered
// one-hot response two cycles after the ack.
module exp_decay_lut_arbiter
    import exp_decay_lut_arbiter_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_VOICES-1:0]           req,
    input  logic [NUM_VOICES*LUT_IDX_W-1:0] req_idx,
    output logic [NUM_VOICES-1:0]           ack,
    output logic [LUT_IDX_W-1:0]            lut_din,
    input  logic [LUT_DATA_W-1:0]           lut_dout,
    output logic [NUM_VOICES-1:0]           rsp_valid,
    output logic [LUT_DATA_W-1:0]           rsp_data
);

    localparam int unsigned ID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [NUM_VOICES-1:0] grant;
    logic [ID_W-1:0]       grant_id;

    logic                  s1_valid_q, s1_valid_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d;
    logic [LUT_IDX_W-1:0]  lut_din_q, lut_din_d;

    logic [NUM_VOICES-1:0] rsp_valid_q, rsp_valid_d;
    logic [LUT_DATA_W-1:0] rsp_data_q, rsp_data_d;

    rr_priority_pick #(
        .N    (NUM_VOICES),
        .ID_W (ID_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .id_o    (grant_id)
    );

    // Ack is the raw grant, suppressed while the block is held in reset.
    always_comb begin
        ack = rst_n ? grant : '0;
    end

    // Next pointer sits just past the winner; stage 1 captures the winner's index.
    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = |ack;
        s1_id_d    = s1_id_q;
        lut_din_d  = lut_din_q;
        if (|ack) begin
            ptr_d   = (grant_id == ID_W'(NUM_VOICES - 1)) ? '0 : grant_id + 1'b1;
            s1_id_d = grant_id;
        end
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (ack[i]) begin
                lut_din_d = req_idx[i*LUT_IDX_W +: LUT_IDX_W];
            end
        end
    end

    // Stage 2 returns the table value to the owning voice as a one-hot pulse.
    always_comb begin
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (s1_valid_q) begin
            rsp_valid_d[s1_id_q] = 1'b1;
            rsp_data_d           = lut_dout;
        end
    end

    // Pipeline and pointer registers; reset discards anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            lut_din_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            ptr_q       <= ptr_d;
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            lut_din_q   <= lut_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign lut_din   = lut_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_exp_decay_lut_arbiter.sv
// Bench for exp_decay_lut_arbiter: vector table, directed corner sequences and
// randomized traffic against a queue-based transaction model.
module tb_exp_decay_lut_arbiter;

    localparam int unsigned NV = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NV-1:0]   req = '0;
    logic [NV*8-1:0] req_idx = '0;
    logic [NV-1:0]   ack;
    logic [7:0]      lut_din;
    logic [7:0]      lut_dout;
    logic [NV-1:0]   rsp_valid;
    logic [7:0]      rsp_data;

    always #5 clk = ~clk;

    // Decay table stand-in: halves every 32 steps, minus a small ramp.
    function automatic logic [7:0] decay(input logic [7:0] x);
        decay = (8'hFF >> x[7:5]) - {3'b000, x[4:0]};
    endfunction

    assign lut_dout = decay(lut_din);

    exp_decay_lut_arbiter #(.NUM_VOICES(NV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_idx   (req_idx),
        .ack       (ack),
        .lut_din   (lut_din),
        .lut_dout  (lut_dout),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction model: pointer, last issued index, last delivered value,
    // and a queue of issued lookups with the cycle they must appear in.
    int         ptr_m = 0;
    logic [7:0] din_m = 8'h00;
    logic [7:0] data_m = 8'h00;
    typedef struct {
        int         voice;
        logic [7:0] idx;
        int         due;
    } flight_t;
    flight_t inflight[$];

    logic [NV-1:0] obs_ack;
    logic [NV-1:0] obs_rv;
    logic [7:0]    obs_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        ptr_m  = 0;
        din_m  = 8'h00;
        data_m = 8'h00;
    endtask

    // One clock cycle: drive, check every output against the model, commit.
    task automatic step(input logic [NV-1:0] r, input logic [NV*8-1:0] ix);
        int            eg;
        int            v;
        logic [NV-1:0] exp_ack;
        logic [NV-1:0] exp_rv;
        @(negedge clk);
        req     = r;
        req_idx = ix;
        #1;
        eg = -1;
        for (int k = 0; k < NV; k++) begin
            v = (ptr_m + k) % NV;
            if (r[v] && eg < 0) eg = v;
        end
        exp_ack = '0;
        if (eg >= 0) exp_ack[eg] = 1'b1;
        exp_rv = '0;
        if (inflight.size() > 0 && inflight[0].due == cyc) begin
            exp_rv[inflight[0].voice] = 1'b1;
            data_m = decay(inflight[0].idx);
            void'(inflight.pop_front());
        end
        obs_ack  = ack;
        obs_rv   = rsp_valid;
        obs_data = rsp_data;
        chk("ack", ack, exp_ack);
        chk("lut_din", lut_din, din_m);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_data", rsp_data, data_m);
        if (eg >= 0) begin
            inflight.push_back('{voice: eg, idx: ix[eg*8 +: 8], due: cyc + 2});
            din_m = ix[eg*8 +: 8];
            ptr_m = (eg + 1) % NV;
        end
        @(posedge clk);
        cyc++;
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
    task automatic reset_pulse();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req   = '1;
        req_idx = 32'hDEADBEEF;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_lut_din", lut_din, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        @(posedge clk);
        cyc++;
    endtask

    typedef struct {
        bit            rst;
        logic [NV-1:0] r;
        logic [31:0]   ix;
        logic [NV-1:0] eack;
        logic [NV-1:0] erv;
        logic [7:0]    edata;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Single request, then four voices streaming from ptr=0.
        vecs[0]  = '{1'b1, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'h00};
        vecs[1]  = '{1'b0, 4'b0001, 32'h0,        4'b0001, 4'b0000, 8'h00};
        vecs[2]  = '{1'b0, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'h00};
        vecs[3]  = '{1'b0, 4'b0000, 32'h0,        4'b0000, 4'b0001, 8'hFF};
        vecs[4]  = '{1'b0, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'hFF};
        vecs[5]  = '{1'b1, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'h00};
        vecs[6]  = '{1'b0, 4'b1111, 32'h40302010, 4'b0001, 4'b0000, 8'h00};
        vecs[7]  = '{1'b0, 4'b1111, 32'h40302010, 4'b0010, 4'b0000, 8'h00};
        vecs[8]  = '{1'b0, 4'b1111, 32'h40302010, 4'b0100, 4'b0001, 8'hEF};
        vecs[9]  = '{1'b0, 4'b1111, 32'h40302010, 4'b1000, 4'b0010, 8'h7F};
        vecs[10] = '{1'b0, 4'b1111, 32'h40302010, 4'b0001, 4'b0100, 8'h6F};
        vecs[11] = '{1'b0, 4'b0000, 32'h0,        4'b0000, 4'b1000, 8'h3F};
        vecs[12] = '{1'b0, 4'b0000, 32'h0,        4'b0000, 4'b0001, 8'hEF};
        vecs[13] = '{1'b0, 4'b0000, 32'h0,        4'b0000, 4'b0000, 8'hEF};

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) begin
                reset_pulse();
            end else begin
                step(vecs[i].r, vecs[i].ix);
                chk("vec_ack", obs_ack, vecs[i].eack);
                chk("vec_rsp_valid", obs_rv, vecs[i].erv);
                chk("vec_rsp_data", obs_data, vecs[i].edata);
            end
        end

        // Fairness: voice 3 held while voice 0 asks every cycle.
        begin
            int   waited;
            logic prev0;
            logic got3;
            reset_pulse();
            waited = 0;
            prev0  = 1'b0;
            got3   = 1'b0;
            for (int k = 0; k < 8 && !got3; k++) begin
                step(4'b1001, 32'h9C000005);
                waited++;
                chk("fair_no_double0", prev0 & obs_ack[0], 0);
                prev0 = obs_ack[0];
                if (obs_ack[3]) got3 = 1'b1;
            end
            chk("fair_bound", (got3 && waited <= 4) ? 1 : 0, 1);
            for (int k = 0; k < 3; k++) step(4'b0000, 32'h0);
        end

        // Withdrawal: voice 2 asks for one cycle while voice 1 wins.
        reset_pulse();
        step(4'b0001, 32'h00000003);
        step(4'b0110, 32'h00221100);
        chk("wd_ack1", obs_ack, 4'b0010);
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 32'h0);
            chk("wd_no_rsp2", obs_rv[2], 0);
        end
        step(4'b1111, 32'h44332211);
        chk("wd_ptr_at2", obs_ack, 4'b0100);
        for (int k = 0; k < 3; k++) step(4'b0000, 32'h0);

        // Reset right after ack[1]: the lookup in flight is dropped.
        reset_pulse();
        step(4'b0010, 32'h00005500);
        chk("mid_ack1", obs_ack, 4'b0010);
        reset_pulse();
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 32'h0);
            chk("mid_no_rsp", obs_rv, 0);
        end
        step(4'b1111, 32'h01020304);
        chk("mid_ptr0", obs_ack, 4'b0001);
        for (int k = 0; k < 3; k++) step(4'b0000, 32'h0);

        // Idle hold after a lookup of 0x7A.
        step(4'b0001, 32'h0000007A);
        for (int k = 0; k < 4; k++) step(4'b0000, 32'h0);
        chk("idle_din", lut_din, 8'h7A);
        chk("idle_data", rsp_data, decay(8'h7A));

        // Random traffic honouring the hold-until-ack handshake, with withdrawals.
        begin
            logic [NV-1:0]   pend;
            logic [NV*8-1:0] pidx;
            logic [NV-1:0]   r;
            reset_pulse();
            pend = '0;
            pidx = '0;
            for (int n = 0; n < 400; n++) begin
                for (int i = 0; i < NV; i++) begin
                    if (!pend[i]) begin
                        if ($urandom % 3 == 0) begin
                            pend[i] = 1'b1;
                            pidx[i*8 +: 8] = 8'($urandom);
                        end
                    end else if ($urandom % 12 == 0) begin
                        pend[i] = 1'b0;
                    end
                end
                r = pend;
                step(r, pidx);
                for (int i = 0; i < NV; i++) begin
                    if (obs_ack[i]) begin
                        pend[i] = 1'($urandom % 2);
                        pidx[i*8 +: 8] = 8'($urandom);
                    end
                end
                if ($urandom % 97 == 0) begin
                    reset_pulse();
                    pend = '0;
                end
            end
            for (int k = 0; k < 3; k++) step(4'b0000, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
